wb_sram_responder: RTL and testbench
====================================

Name: wb_sram_responder

Overview:
- Wishbone classic responder that serves the CPU's data/instruction master ports from an external asynchronous 32-bit SRAM.
- Translates each Wishbone cycle into a timed SRAM read or write sequence and returns a single-cycle ack.
- Sits between the bus side of the CPU memory stage (or instruction fetch) and the board SRAM pins; one instance per SRAM bank.

Parameters:
- DATA_WIDTH, 32, Wishbone and SRAM data width (only 32 supported).
- ADDR_WIDTH, 32, Wishbone byte-address width.
- SRAM_ADDR_WIDTH, 20, SRAM word-address width.
- READ_WAIT, 1, extra cycles the SRAM read strobe is held (0..7).
- WRITE_WAIT, 0, extra cycles the we_n pulse is held (0..7).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-low (asserted = 0).
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  DATA_WIDTH/8  byte enables.
- wb_ack_o  out  1  transfer acknowledge, registered.
- wb_dat_o  out  DATA_WIDTH  read data, registered.
- sram_addr_o  out  SRAM_ADDR_WIDTH  word address.
- sram_data_i  in  DATA_WIDTH  SRAM data pins (input side).
- sram_data_o  out  DATA_WIDTH  SRAM data to drive.
- sram_data_oe  out  1  1 = drive sram_data_o onto pins.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_be_n  out  DATA_WIDTH/8  byte enables, active-low.

Behaviour:
- All outputs are registered.
- Reset (rst_i = 0, asynchronous) sets:
  - wb_ack_o = 0, wb_dat_o = 0;
  - sram_ce_n = sram_oe_n = sram_we_n = 1, sram_be_n = all 1s;
  - sram_addr_o = 0, sram_data_o = 0, sram_data_oe = 0;
  - state = IDLE, wait counter = 0, abort flag = 0.
- Reset mid-transaction releases the SRAM immediately; no ack is issued.
- Address mapping: sram_addr_o = wb_adr_i[SRAM_ADDR_WIDTH+1:2]. Bits [1:0] and upper bits are ignored, so higher addresses alias. Data is always a full word; the master extracts bytes. sram_be_n = ~wb_sel_i.
- Request accepted in IDLE when wb_cyc_i & wb_stb_i & ~wb_ack_o. Address, sel, data and we are latched at that edge. Call that cycle 0.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE, read request -> RD. In RD: ce_n = 0, oe_n = 0.
  - Stays READ_WAIT+1 cycles (counter).
  - On the last RD edge, sram_data_i is captured into wb_dat_o -> DONE.
  - Ack in cycle READ_WAIT+2 (default: cycle 3).
- IDLE, write request with nonzero sel -> WR_SETUP:
  - WR_SETUP: ce_n = 0, data_oe = 1, we_n = 1; 1 cycle.
  - WR_PULSE: we_n = 0; WRITE_WAIT+1 cycles.
  - WR_HOLD: we_n = 1, ce_n = 0, data still driven; 1 cycle.
  - Then DONE. Ack in cycle WRITE_WAIT+4 (default: cycle 4).
  - sram_data_o and sram_be_n stay stable from WR_SETUP through WR_HOLD.
- IDLE, write request with sel = 0: no SRAM activity -> DONE; ack in cycle 1.
- DONE:
  - SRAM controls deasserted, data_oe = 0, oe_n = 1.
  - wb_ack_o = 1 for exactly one cycle unless the abort flag is set.
  - Next state IDLE. A request still held there is treated as a new transfer (earliest re-accept is the cycle after ack).
- Abort (wb_cyc_i = 0 while busy):
  - In RD: go to IDLE at the next edge, SRAM released, no ack, wb_dat_o unchanged.
  - In any WR state: the write sequence completes (we_n pulse is never truncated). The abort flag is set, which suppresses ack in DONE.
- wb_dat_o holds its last captured value; it is unchanged by writes.
- sram_oe_n and sram_we_n are never low in the same cycle.
- sram_data_oe and sram_oe_n = 0 are never active in the same cycle.

Decomposition:
- Shared package memory_pkg holds:
  - state enum (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE);
  - SRAM timing defaults READ_WAIT_DEF and WRITE_WAIT_DEF;
  - SEL_WIDTH = DATA_WIDTH/8.
- Single module; no sub-module. The wait counter is a 3-bit register inside the FSM.

Test Plan:
- Reset: hold rst_i = 0 with random bus inputs -> all outputs at reset values. Release -> IDLE, no ack.
- Read, READ_WAIT = 1: adr 0x8000_0010, SRAM model returns 0xDEADBEEF.
  - sram_addr_o = 0x00004.
  - ce_n/oe_n low in cycles 1-2.
  - ack high only in cycle 3 with wb_dat_o = 0xDEADBEEF.
- Byte write, WRITE_WAIT = 0: adr 0x8000_0005, sel 4'b0010, dat 0x0000_AB00.
  - sram_be_n = 4'b1101.
  - we_n low only in cycle 2; data_oe high in cycles 1-3; SRAM byte 1 = 0xAB.
  - ack in cycle 4.
- Back-to-back: write then read to the same address with stb held.
  - Second request accepted the cycle after the first ack.
  - Read returns the written word; exactly two acks.
- Abort: drop cyc in WR_PULSE -> we_n pulse completes at full width, no ack. Drop cyc in RD -> IDLE next edge, no ack.
- Reset mid-write, asserted during WR_PULSE -> we_n, ce_n and data_oe deassert immediately and asynchronously; no ack after release. Also: write with sel = 0 -> no ce_n activity, ack in cycle 1.

Source files
------------

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and timing defaults for the SRAM responder
package memory_pkg;

  // Responder sequencing states
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  // Default SRAM strobe stretch, in extra clock cycles
  localparam int READ_WAIT_DEF  = 1;
  localparam int WRITE_WAIT_DEF = 0;

  // Bus data width and the matching byte-enable width
  localparam int DATA_WIDTH_DEF = 32;
  localparam int SEL_WIDTH      = DATA_WIDTH_DEF / 8;

endpackage

// File: rtl/wb_sram_responder_if.sv
// rtl/wb_sram_responder_if.sv - Wishbone classic bus bundle between CPU master and SRAM responder
interface wb_sram_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic                    wb_ack_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_dat_o
  );

endinterface

// File: rtl/wb_sram_responder.sv
// rtl/wb_sram_responder.sv - Wishbone classic responder driving an asynchronous 32-bit SRAM
module wb_sram_responder
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int READ_WAIT       = READ_WAIT_DEF,
  parameter int WRITE_WAIT      = WRITE_WAIT_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  wb_sram_responder_if.slave         wb,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [DATA_WIDTH-1:0]      sram_data_i,
  output logic [DATA_WIDTH-1:0]      sram_data_o,
  output logic                       sram_data_oe,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic [SEL_WIDTH-1:0]       sram_be_n
);

  localparam logic [2:0] RD_CNT = 3'(READ_WAIT);
  localparam logic [2:0] WR_CNT = 3'(WRITE_WAIT);

  state_t                state;
  logic [2:0]            wait_cnt;
  logic                  abort_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  req;

  // Byte-offset bits and bits above the SRAM window alias and are dropped
  logic unused_adr;
  assign unused_adr = ^{wb.wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb.wb_adr_i[1:0]};

  assign req         = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  // Sequencer: every SRAM pin and the ack are registered so strobes are glitch-free
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      abort_q      <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      sram_addr_o  <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= '1;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr_o <= wb.wb_adr_i[SRAM_ADDR_WIDTH+1:2];
            sram_data_o <= wb.wb_dat_i;
            abort_q     <= 1'b0;
            if (!wb.wb_we_i) begin
              state     <= RD;
              wait_cnt  <= RD_CNT;
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              sram_be_n <= ~wb.wb_sel_i;
            end else if (wb.wb_sel_i != '0) begin
              state        <= WR_SETUP;
              sram_ce_n    <= 1'b0;
              sram_data_oe <= 1'b1;
              sram_be_n    <= ~wb.wb_sel_i;
            end else begin
              // Write with no lanes enabled: acknowledge without touching the SRAM
              state <= DONE;
              ack_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (!wb.wb_cyc_i) begin
            // Master gave up: release the chip, keep the previous read data
            state     <= IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
          end else if (wait_cnt == 3'd0) begin
            state     <= DONE;
            dat_q     <= sram_data_i;
            ack_q     <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          wait_cnt  <= WR_CNT;
          sram_we_n <= 1'b0;
          if (!wb.wb_cyc_i) abort_q <= 1'b1;
        end
        WR_PULSE: begin
          // The we_n pulse always runs to full width, even when aborted
          if (wait_cnt == 3'd0) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
          if (!wb.wb_cyc_i) abort_q <= 1'b1;
        end
        WR_HOLD: begin
          state        <= DONE;
          ack_q        <= ~(abort_q | ~wb.wb_cyc_i);
          sram_ce_n    <= 1'b1;
          sram_data_oe <= 1'b0;
          sram_be_n    <= '1;
        end
        DONE: begin
          state   <= IDLE;
          abort_q <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          sram_ce_n    <= 1'b1;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= 1'b1;
          sram_data_oe <= 1'b0;
          sram_be_n    <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_responder.sv
// tb/tb_wb_sram_responder.sv - directed self-checking bench for wb_sram_responder
module tb_wb_sram_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_data_i;
  logic [31:0] sram_data_o;
  logic        sram_data_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];

  logic [7:0]  ce_v, oe_v, we_v, doe_v, ack_v;
  logic [19:0] addr_c1;
  logic [3:0]  be_c1, be_c3;
  logic [31:0] dout_c1, dout_c3, dat_ack;
  logic [15:0] ack16, oe16;
  int          n_ack;

  wb_sram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wbif ();

  wb_sram_responder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wb           (wbif),
    .sram_addr_o  (sram_addr_o),
    .sram_data_i  (sram_data_i),
    .sram_data_o  (sram_data_o),
    .sram_data_oe (sram_data_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_be_n    (sram_be_n)
  );

  always #5 clk_i = ~clk_i;

  // Asynchronous SRAM model: reads while ce_n/oe_n low, writes on rising we_n
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o[7:0]] : 32'h0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h1122_3344;
    mem[4] = 32'hDEAD_BEEF;
    mem[9] = 32'h55AA_55AA;
    forever begin
      @(posedge sram_we_n);
      if (!sram_ce_n) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) mem[sram_addr_o[7:0]][8*b +: 8] = sram_data_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transfer, sampled #1 after each of the next 7 edges; cyc drops on ack or at abort_cycle
  task automatic run_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int abort_cycle);
    ce_v = 8'h0; oe_v = 8'h0; we_v = 8'h0; doe_v = 8'h0; ack_v = 8'h0;
    dat_ack = 32'hX;
    @(negedge clk_i);
    wbif.wb_cyc_i = 1'b1;
    wbif.wb_stb_i = 1'b1;
    wbif.wb_we_i  = we;
    wbif.wb_adr_i = adr;
    wbif.wb_dat_i = dat;
    wbif.wb_sel_i = sel;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk_i);
      #1;
      ce_v[k]  = sram_ce_n;
      oe_v[k]  = sram_oe_n;
      we_v[k]  = sram_we_n;
      doe_v[k] = sram_data_oe;
      ack_v[k] = wbif.wb_ack_o;
      if (k == 1) begin addr_c1 = sram_addr_o; be_c1 = sram_be_n; dout_c1 = sram_data_o; end
      if (k == 3) begin be_c3 = sram_be_n; dout_c3 = sram_data_o; end
      if (wbif.wb_ack_o) dat_ack = wbif.wb_dat_o;
      if (wbif.wb_ack_o || k == abort_cycle) begin
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset held with random bus activity
    wbif.wb_cyc_i = 1'b1;
    wbif.wb_stb_i = 1'b1;
    wbif.wb_we_i  = 1'b0;
    wbif.wb_adr_i = 32'h0;
    wbif.wb_dat_i = 32'h0;
    wbif.wb_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      wbif.wb_we_i  = 1'($urandom_range(0, 1));
      wbif.wb_adr_i = $urandom;
      wbif.wb_dat_i = $urandom;
      wbif.wb_sel_i = 4'($urandom_range(0, 15));
    end
    @(negedge clk_i);
    check("rst_ack",   {31'h0, wbif.wb_ack_o}, 32'h0);
    check("rst_dat",   wbif.wb_dat_o, 32'h0);
    check("rst_ctl",   {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    check("rst_be",    {28'h0, sram_be_n}, 32'hF);
    check("rst_addr",  {12'h0, sram_addr_o}, 32'h0);
    check("rst_dout",  sram_data_o, 32'h0);
    check("rst_oe",    {31'h0, sram_data_oe}, 32'h0);
    wbif.wb_cyc_i = 1'b0;
    wbif.wb_stb_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rel_ack",  {31'h0, wbif.wb_ack_o}, 32'h0);
    check("rel_ce",   {31'h0, sram_ce_n}, 32'h1);

    // Read of 0x8000_0010 -> word 4 holding 0xDEADBEEF
    run_req(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0);
    check("rd_addr", {12'h0, addr_c1}, 32'h4);
    check("rd_ce",   {24'h0, ce_v}, 32'hF8);
    check("rd_oe",   {24'h0, oe_v}, 32'hF8);
    check("rd_we",   {24'h0, we_v}, 32'hFE);
    check("rd_doe",  {24'h0, doe_v}, 32'h00);
    check("rd_ack",  {24'h0, ack_v}, 32'h08);
    check("rd_dat",  dat_ack, 32'hDEAD_BEEF);

    // Byte write to 0x8000_0005, lane 1
    run_req(1'b1, 32'h8000_0005, 32'h0000_AB00, 4'b0010, 0);
    check("bw_addr", {12'h0, addr_c1}, 32'h1);
    check("bw_be1",  {28'h0, be_c1}, 32'hD);
    check("bw_be3",  {28'h0, be_c3}, 32'hD);
    check("bw_d1",   dout_c1, 32'h0000_AB00);
    check("bw_d3",   dout_c3, 32'h0000_AB00);
    check("bw_we",   {24'h0, we_v}, 32'hFA);
    check("bw_doe",  {24'h0, doe_v}, 32'h0E);
    check("bw_ce",   {24'h0, ce_v}, 32'hF0);
    check("bw_oe",   {24'h0, oe_v}, 32'hFE);
    check("bw_ack",  {24'h0, ack_v}, 32'h10);
    check("bw_mem",  mem[1], 32'h1122_AB44);
    check("bw_dato", wbif.wb_dat_o, 32'hDEAD_BEEF);

    // Back-to-back write then read of word 4 with stb held
    ack16 = 16'h0; oe16 = 16'h0; n_ack = 0; dat_ack = 32'h0;
    @(negedge clk_i);
    wbif.wb_cyc_i = 1'b1;
    wbif.wb_stb_i = 1'b1;
    wbif.wb_we_i  = 1'b1;
    wbif.wb_adr_i = 32'h0000_0010;
    wbif.wb_dat_i = 32'hCAFE_F00D;
    wbif.wb_sel_i = 4'hF;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk_i);
      #1;
      ack16[k] = wbif.wb_ack_o;
      oe16[k]  = sram_oe_n;
      if (wbif.wb_ack_o) begin
        n_ack++;
        dat_ack = wbif.wb_dat_o;
        if (n_ack == 1) wbif.wb_we_i = 1'b0;
        else begin
          wbif.wb_cyc_i = 1'b0;
          wbif.wb_stb_i = 1'b0;
        end
      end
    end
    check("b2b_ack", {16'h0, ack16}, 32'h0110);
    check("b2b_oe",  {16'h0, oe16}, 32'h0F3E);
    check("b2b_dat", dat_ack, 32'hCAFE_F00D);
    check("b2b_mem", mem[4], 32'hCAFE_F00D);

    // Abort a write during the we_n pulse
    run_req(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 2);
    check("aw_we",  {24'h0, we_v}, 32'hFA);
    check("aw_ce",  {24'h0, ce_v}, 32'hF0);
    check("aw_ack", {24'h0, ack_v}, 32'h00);
    check("aw_mem", mem[8], 32'h1234_5678);

    // Abort a read in its first RD cycle
    run_req(1'b0, 32'h0000_0024, 32'h0, 4'hF, 1);
    check("ar_ce",  {24'h0, ce_v}, 32'hFC);
    check("ar_oe",  {24'h0, oe_v}, 32'hFC);
    check("ar_ack", {24'h0, ack_v}, 32'h00);
    check("ar_dat", wbif.wb_dat_o, 32'hCAFE_F00D);

    // Write with no byte lanes
    run_req(1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 0);
    check("s0_ce",  {24'h0, ce_v}, 32'hFE);
    check("s0_we",  {24'h0, we_v}, 32'hFE);
    check("s0_ack", {24'h0, ack_v}, 32'h02);

    // Reset asserted during the we_n pulse
    @(negedge clk_i);
    wbif.wb_cyc_i = 1'b1;
    wbif.wb_stb_i = 1'b1;
    wbif.wb_we_i  = 1'b1;
    wbif.wb_adr_i = 32'h0000_0028;
    wbif.wb_dat_i = 32'hA5A5_A5A5;
    wbif.wb_sel_i = 4'hF;
    repeat (2) @(posedge clk_i);
    #1;
    check("rw_pulse", {31'h0, sram_we_n}, 32'h0);
    #1;
    rst_i = 1'b0;
    #1;
    check("rw_ctl", {29'h0, sram_we_n, sram_ce_n, sram_data_oe}, 32'h6);
    wbif.wb_cyc_i = 1'b0;
    wbif.wb_stb_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i);
      #1;
      if (wbif.wb_ack_o) n_ack++;
    end
    check("rw_noack", 32'(n_ack), 32'h0);
    check("rw_idle",  {31'h0, sram_ce_n}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
